// File: rtl/ax_bltcyc_update_queue_pkg.sv
// ax_bltcyc_update_queue_pkg: shared widths, entry types and PC-to-BTB field helpers
package ax_bltcyc_update_queue_pkg;
  localparam int PC_W = 32;
  localparam int INSN_SHIFT = 2;
  localparam int AXBTB_INDEX_W = 6;
  localparam int AXBLTCYCBTB_TAG_W = 8;
  localparam int BTB_ADDR_W = 14;
  localparam int AXBLTCYC_UPD_DEPTH = 8;
  localparam int AXBTB_BANK_NUM = 2;
  localparam int AXBTB_BANK_W = $clog2(AXBTB_BANK_NUM);
  typedef logic [PC_W-1:0] pc_path_t;
  typedef logic [AXBTB_INDEX_W-1:0] axbtb_index_t;
  typedef logic [AXBTB_BANK_W-1:0] axbtb_bank_t;
  typedef logic [AXBLTCYCBTB_TAG_W-1:0] axbltcycbtb_tag_t;
  typedef logic [BTB_ADDR_W-1:0] btb_addr_t;
  typedef struct packed {
    pc_path_t br_addr;
    pc_path_t next_addr;
  } ax_bltcyc_upd_entry_t;
  typedef struct packed {
    logic             valid;
    axbltcycbtb_tag_t tag;
    btb_addr_t        data;
  } axbltcycbtb_entry_t;
  localparam int AXBLTCYCBTB_ENTRY_W = $bits(axbltcycbtb_entry_t);
  function automatic axbtb_index_t to_axbtb_index(input pc_path_t pc);
    return pc[INSN_SHIFT +: AXBTB_INDEX_W];
  endfunction
  function automatic axbltcycbtb_tag_t to_axbltcycbtb_tag(input pc_path_t pc);
    return pc[INSN_SHIFT+AXBTB_INDEX_W +: AXBLTCYCBTB_TAG_W];
  endfunction
  function automatic btb_addr_t to_btb_addr(input pc_path_t pc);
    return pc[INSN_SHIFT +: BTB_ADDR_W];
  endfunction
  function automatic axbtb_bank_t to_axbtb_bank(input axbtb_index_t idx);
    return idx[AXBTB_BANK_W-1:0];
  endfunction
endpackage

// File: rtl/ax_bltcyc_update_queue_drain_select.sv
// ax_bltcyc_drain_select: head-ordered selector that stops at the first bank conflict
module ax_bltcyc_drain_select
  import ax_bltcyc_update_queue_pkg::*;
#(
  parameter int WRITE_NUM = 2,
  parameter int DEPTH = AXBLTCYC_UPD_DEPTH
) (
  input  logic [$clog2(DEPTH)-1:0]                    i_head,
  input  logic [$clog2(DEPTH):0]                      i_count,
  input  logic [DEPTH-1:0][AXBTB_BANK_W-1:0]          i_bank,
  input  logic                                        i_stall,
  output logic [WRITE_NUM-1:0]                        o_sel,
  output logic [WRITE_NUM-1:0][$clog2(DEPTH)-1:0]     o_off,
  output logic [$clog2(DEPTH):0]                      o_pop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic                      w_stop;
  logic [AXBTB_BANK_NUM-1:0] w_used;
  logic [AXBTB_BANK_W-1:0]   w_bank;
  always_comb begin
    o_sel = '0;
    o_off = '0;
    o_pop = '0;
    w_stop = i_stall;
    w_used = '0;
    w_bank = '0;
    for (int k = 0; k < WRITE_NUM; k++) begin
      o_off[k] = PTR_W'(k);
      w_bank = i_bank[i_head + PTR_W'(k)];
      if (!w_stop && CNT_W'(k) < i_count && !w_used[w_bank]) begin
        o_sel[k] = 1'b1;
        w_used[w_bank] = 1'b1;
        o_pop = o_pop + CNT_W'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ax_bltcyc_update_queue.sv
// ax_bltcyc_update_queue: coalescing FIFO feeding bank-conflict-free writes to the AX BLT-cycle BTB
module ax_bltcyc_update_queue
  import ax_bltcyc_update_queue_pkg::*;
#(
  parameter int WRITE_NUM = 2,
  parameter int DEPTH = AXBLTCYC_UPD_DEPTH
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [WRITE_NUM-1:0]                        i_valid,
  input  logic [WRITE_NUM-1:0]                        i_is_ap_blt_cyc,
  input  logic [WRITE_NUM-1:0][PC_W-1:0]              i_br_addr,
  input  logic [WRITE_NUM-1:0][PC_W-1:0]              i_next_addr,
  input  logic                                        i_drain_stall,
  output logic [WRITE_NUM-1:0]                        o_we,
  output logic [WRITE_NUM-1:0][AXBTB_INDEX_W-1:0]     o_wa,
  output logic [WRITE_NUM-1:0][AXBLTCYCBTB_ENTRY_W-1:0] o_wv,
  output logic                                        o_full,
  output logic [$clog2(DEPTH):0]                      o_count,
  output logic [15:0]                                 o_drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  pc_path_t                                   r_br [DEPTH];
  pc_path_t                                   r_next [DEPTH];
  logic [PTR_W-1:0]                           r_head, r_tail;
  logic [CNT_W-1:0]                           r_count;
  logic                                       r_full;
  logic [15:0]                                r_drop;
  logic [WRITE_NUM-1:0]                       r_we;
  logic [WRITE_NUM-1:0][AXBTB_INDEX_W-1:0]    r_wa;
  logic [WRITE_NUM-1:0][AXBLTCYCBTB_ENTRY_W-1:0] r_wv;
  logic [DEPTH-1:0][AXBTB_BANK_W-1:0]         w_bank;
  logic [WRITE_NUM-1:0]                       w_sel, w_acc, w_rep, w_push;
  logic [WRITE_NUM-1:0][PTR_W-1:0]            w_off, w_rd, w_pslot;
  logic [CNT_W-1:0]                           w_pop, w_free, w_npush, w_ndrop, w_count_nxt;
  logic [PTR_W-1:0]                           w_off_p;
  logic [DEPTH-1:0]                           w_res, w_drn;
  logic [WRITE_NUM-1:0][DEPTH-1:0]            w_hit;
  logic [16:0]                                w_drop_sum;
  assign o_we = r_we;
  assign o_wa = r_wa;
  assign o_wv = r_wv;
  assign o_full = r_full;
  assign o_count = r_count;
  assign o_drop_count = r_drop;
  always_comb
    for (int p = 0; p < DEPTH; p++) w_bank[p] = to_axbtb_bank(to_axbtb_index(r_br[p]));
  ax_bltcyc_drain_select #(.WRITE_NUM(WRITE_NUM), .DEPTH(DEPTH)) u_sel (
    .i_head(r_head), .i_count(r_count), .i_bank(w_bank), .i_stall(i_drain_stall),
    .o_sel(w_sel), .o_off(w_off), .o_pop(w_pop)
  );
  assign w_free = CNT_W'(DEPTH) - r_count;
  // The highest matching lane is the surviving representative, so it already carries the winning nextAddr.
  always_comb begin
    w_acc = i_valid & i_is_ap_blt_cyc;
    w_rep = w_acc;
    w_res = '0;
    w_drn = '0;
    w_hit = '0;
    w_push = '0;
    w_pslot = '0;
    w_npush = '0;
    w_ndrop = '0;
    w_off_p = '0;
    w_rd = '0;
    for (int i = 0; i < WRITE_NUM; i++)
      for (int j = i + 1; j < WRITE_NUM; j++)
        if (w_acc[j] && i_br_addr[j] == i_br_addr[i]) w_rep[i] = 1'b0;
    for (int p = 0; p < DEPTH; p++) begin
      w_off_p = PTR_W'(p) - r_head;
      w_res[p] = CNT_W'(w_off_p) < r_count;
      w_drn[p] = w_res[p] && CNT_W'(w_off_p) < w_pop;
    end
    for (int i = 0; i < WRITE_NUM; i++)
      for (int p = 0; p < DEPTH; p++)
        w_hit[i][p] = w_rep[i] && w_res[p] && !w_drn[p] && r_br[p] == i_br_addr[i];
    for (int i = 0; i < WRITE_NUM; i++)
      if (w_rep[i] && !(|w_hit[i])) begin
        if (w_npush < w_free) begin
          w_push[i] = 1'b1;
          w_pslot[i] = r_tail + w_npush[PTR_W-1:0];
          w_npush = w_npush + CNT_W'(1);
        end else begin
          w_ndrop = w_ndrop + CNT_W'(1);
        end
      end
    for (int k = 0; k < WRITE_NUM; k++) w_rd[k] = r_head + w_off[k];
  end
  assign w_count_nxt = r_count + w_npush - w_pop;
  assign w_drop_sum = 17'(r_drop) + 17'(w_ndrop);
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_NUM; i++)
      for (int p = 0; p < DEPTH; p++)
        if (w_hit[i][p]) r_next[p] <= i_next_addr[i];
    for (int i = 0; i < WRITE_NUM; i++)
      if (w_push[i]) begin
        r_br[w_pslot[i]] <= i_br_addr[i];
        r_next[w_pslot[i]] <= i_next_addr[i];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_drop <= '0;
      r_we <= '0;
      r_wa <= '0;
      r_wv <= '0;
    end else begin
      r_head <= r_head + w_pop[PTR_W-1:0];
      r_tail <= r_tail + w_npush[PTR_W-1:0];
      r_count <= w_count_nxt;
      r_full <= w_count_nxt == CNT_W'(DEPTH);
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      for (int k = 0; k < WRITE_NUM; k++) begin
        r_we[k] <= w_sel[k];
        r_wa[k] <= w_sel[k] ? to_axbtb_index(r_br[w_rd[k]]) : '0;
        r_wv[k] <= w_sel[k] ? axbltcycbtb_entry_t'{valid: 1'b1, tag: to_axbltcycbtb_tag(r_br[w_rd[k]]),
                                                   data: to_btb_addr(r_next[w_rd[k]])} : '0;
      end
    end
endmodule

// File: tb/tb_ax_bltcyc_update_queue.sv
// tb_ax_bltcyc_update_queue: directed checks of capture, coalescing, bank-ordered drain, drops and reset
module tb_ax_bltcyc_update_queue;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        i_valid = '0, i_is_ap_blt_cyc = '0;
  logic [1:0][31:0]  i_br_addr = '0, i_next_addr = '0;
  logic              i_drain_stall = 1'b0;
  logic [1:0]        o_we;
  logic [1:0][5:0]   o_wa;
  logic [1:0][22:0]  o_wv;
  logic              o_full;
  logic [3:0]        o_count;
  logic [15:0]       o_drop_count;
  int                n_chk = 0, n_fail = 0;
  ax_bltcyc_update_queue #(.WRITE_NUM(2), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_is_ap_blt_cyc(i_is_ap_blt_cyc),
    .i_br_addr(i_br_addr), .i_next_addr(i_next_addr), .i_drain_stall(i_drain_stall),
    .o_we(o_we), .o_wa(o_wa), .o_wv(o_wv), .o_full(o_full), .o_count(o_count),
    .o_drop_count(o_drop_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v0, input logic [31:0] b0, input logic [31:0] n0,
                     input logic v1, input logic [31:0] b1, input logic [31:0] n1);
    i_valid = {v1, v0};
    i_is_ap_blt_cyc = {v1, v0};
    i_br_addr = {b1, b0};
    i_next_addr = {n1, n0};
  endtask
  initial begin
    #3;
    chk("rst_we", 64'(o_we), 0);
    chk("rst_count", 64'(o_count), 0);
    chk("rst_full", 64'(o_full), 0);
    chk("rst_drop", 64'(o_drop_count), 0);
    chk("rst_wa_wv", 64'({o_wa, o_wv}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // single lane
    drv(1, 32'h1000, 32'h0F00, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("t1_count_resident", 64'(o_count), 1);
    chk("t1_we_early", 64'(o_we), 0);
    tick();
    chk("t1_we", 64'(o_we), 2'b01);
    chk("t1_wa", 64'(o_wa[0]), 0);
    chk("t1_wv", 64'(o_wv[0]), 64'({1'b1, 8'h10, 14'h03C0}));
    chk("t1_count_empty", 64'(o_count), 0);
    tick();
    chk("t1_we_idle", 64'(o_we), 0);
    // valid but not an AP BLT-cycle branch is ignored
    i_valid = 2'b01;
    i_br_addr[0] = 32'h5000;
    tick();
    i_valid = '0;
    chk("notap_count", 64'(o_count), 0);
    // intra-cycle duplicates
    drv(1, 32'h2000, 32'h2100, 1, 32'h2000, 32'h2200);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("t2_count", 64'(o_count), 1);
    tick();
    chk("t2_we", 64'(o_we), 2'b01);
    chk("t2_wv", 64'(o_wv[0]), 64'({1'b1, 8'h20, 14'h0880}));
    chk("t2_count_empty", 64'(o_count), 0);
    // coalescing under stall
    i_drain_stall = 1'b1;
    drv(1, 32'h3000, 32'h10, 0, 0, 0);
    tick();
    chk("t3_count_a", 64'(o_count), 1);
    drv(1, 32'h3000, 32'h20, 0, 0, 0);
    tick();
    chk("t3_count_b", 64'(o_count), 1);
    drv(1, 32'h3000, 32'h30, 0, 0, 0);
    tick();
    chk("t3_count_c", 64'(o_count), 1);
    chk("t3_we_stalled", 64'(o_we), 0);
    drv(0, 0, 0, 0, 0, 0);
    i_drain_stall = 1'b0;
    tick();
    chk("t3_we", 64'(o_we), 2'b01);
    chk("t3_wv", 64'(o_wv[0]), 64'({1'b1, 8'h30, 14'h000C}));
    chk("t3_count_empty", 64'(o_count), 0);
    // same bank: one per cycle
    i_drain_stall = 1'b1;
    drv(1, 32'h1000, 32'h1100, 1, 32'h2000, 32'h2200);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("t4_count", 64'(o_count), 2);
    i_drain_stall = 1'b0;
    tick();
    chk("t4_we_a", 64'(o_we), 2'b01);
    chk("t4_wv_a", 64'(o_wv[0]), 64'({1'b1, 8'h10, 14'h0440}));
    chk("t4_count_a", 64'(o_count), 1);
    tick();
    chk("t4_we_b", 64'(o_we), 2'b01);
    chk("t4_wv_b", 64'(o_wv[0]), 64'({1'b1, 8'h20, 14'h0880}));
    chk("t4_count_b", 64'(o_count), 0);
    // different banks: both ports in one cycle
    i_drain_stall = 1'b1;
    drv(1, 32'h1000, 32'h1100, 1, 32'h1004, 32'h1200);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    i_drain_stall = 1'b0;
    tick();
    chk("t4d_we", 64'(o_we), 2'b11);
    chk("t4d_wa", 64'({o_wa[1], o_wa[0]}), 64'({6'd1, 6'd0}));
    chk("t4d_wv1", 64'(o_wv[1]), 64'({1'b1, 8'h10, 14'h0480}));
    chk("t4d_count", 64'(o_count), 0);
    // fill and overflow
    i_drain_stall = 1'b1;
    drv(1, 32'h4000, 0, 1, 32'h4008, 0);
    tick();
    drv(1, 32'h4004, 0, 1, 32'h400C, 0);
    tick();
    drv(1, 32'h4010, 0, 1, 32'h4014, 0);
    tick();
    drv(1, 32'h4018, 0, 1, 32'h401C, 0);
    tick();
    chk("t5_count_full", 64'(o_count), 8);
    chk("t5_full", 64'(o_full), 1);
    chk("t5_drop_none", 64'(o_drop_count), 0);
    drv(1, 32'h6000, 0, 1, 32'h6004, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("t5_drop", 64'(o_drop_count), 2);
    chk("t5_count_after_drop", 64'(o_count), 8);
    chk("t5_full_after_drop", 64'(o_full), 1);
    // drain with a bank conflict at the second entry
    i_drain_stall = 1'b0;
    tick();
    chk("t6_we_a", 64'(o_we), 2'b01);
    chk("t6_wa_a", 64'(o_wa[0]), 0);
    chk("t6_count_a", 64'(o_count), 7);
    chk("t6_full_a", 64'(o_full), 0);
    tick();
    chk("t6_we_b", 64'(o_we), 2'b11);
    chk("t6_wa_b", 64'({o_wa[1], o_wa[0]}), 64'({6'd1, 6'd2}));
    chk("t6_count_b", 64'(o_count), 5);
    // asynchronous reset mid-drain
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 64'(o_we), 0);
    chk("t6_rst_count", 64'(o_count), 0);
    chk("t6_rst_drop", 64'(o_drop_count), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_post_rst_we", 64'(o_we), 0);
    drv(1, 32'h1000, 32'h0F00, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("t6_fresh_count", 64'(o_count), 1);
    tick();
    chk("t6_fresh_we", 64'(o_we), 2'b01);
    chk("t6_fresh_wv", 64'(o_wv[0]), 64'({1'b1, 8'h10, 14'h03C0}));
    chk("t6_fresh_count_empty", 64'(o_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
